// File: rtl/spi_master.sv
// Single-byte SPI master with two chip selects, runtime CPOL/CPHA and SCLK rate.
// Optional macro SPI_LSB_FIRST_EN: shift LSB-first in both directions instead of MSB-first.
module spi_master #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pulse1,
  input  logic        pulse2,
  input  logic [31:0] speed,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [7:0]  data2send,
  input  logic        miso,
  output logic        sclk,
  output logic        cs1,
  output logic        cs2,
  output logic        mosi,
  output logic [7:0]  data_received,
  output logic [1:0]  state_dbg
);

  // Handshake: pulse1/pulse2 are single-cycle strobes honoured only in S_IDLE;
  // there is no ready/ack, a transfer is complete when both chip selects are high again.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_END   = 2'd2
  } state_t;

  localparam logic [31:0] CLK_HALF = 32'(CLK_FREQ_HZ / 2);

  state_t      state_q, state_d;
  logic [31:0] half_q, half_calc, half_div;
  logic [31:0] cnt_q;
  logic [3:0]  tog_q;
  logic        sclk_q, cpol_q, cpha_q;
  logic [7:0]  tx_q, rx_q, rx_next, tx_init;
  logic        start, half_tick, sample_now, shift_now;

  // floor(floor(C/2)/s) equals floor(C/(2s)), which keeps the divider 32 bits wide
  always_comb begin
    half_div  = 32'd0;
    half_calc = 32'd1;
    if (speed != 32'd0) begin
      half_div = CLK_HALF / speed;
      if (half_div != 32'd0) half_calc = half_div;
    end
  end

`ifdef SPI_LSB_FIRST_EN
  always_comb begin
    tx_init = 8'd0;
    for (int i = 0; i < 8; i++) tx_init[i] = data2send[7-i];
  end
  assign rx_next = {miso, rx_q[7:1]};
`else
  assign tx_init = data2send;
  assign rx_next = {rx_q[6:0], miso};
`endif

  assign start      = pulse1 | pulse2;
  assign half_tick  = (cnt_q == half_q - 32'd1);
  // tog_q counts completed toggles, so tog_q[0]==0 means the upcoming toggle is odd
  assign sample_now = (tog_q[0] == cpha_q);
  assign shift_now  = !sample_now && (tog_q != 4'd15);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (half_tick && tog_q == 4'd15) state_d = S_END;
      S_END:   if (half_tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cs1           <= 1'b1;
      cs2           <= 1'b1;
      mosi          <= 1'b0;
      data_received <= 8'd0;
      sclk_q        <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      half_q        <= 32'd1;
      cnt_q         <= 32'd0;
      tog_q         <= 4'd0;
      tx_q          <= 8'd0;
      rx_q          <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            half_q <= half_calc;
            cs1    <= !pulse1;
            cs2    <= pulse1;
            sclk_q <= cpol;
            cnt_q  <= 32'd0;
            tog_q  <= 4'd0;
            rx_q   <= 8'd0;
            if (!cpha) begin
              mosi <= tx_init[7];
              tx_q <= {tx_init[6:0], 1'b0};
            end else begin
              tx_q <= tx_init;
            end
          end
        end
        S_SHIFT: begin
          if (half_tick) begin
            cnt_q  <= 32'd0;
            sclk_q <= ~sclk_q;
            tog_q  <= tog_q + 4'd1;
            if (sample_now) rx_q <= rx_next;
            if (shift_now) begin
              mosi <= tx_q[7];
              tx_q <= {tx_q[6:0], 1'b0};
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_END: begin
          if (half_tick) begin
            cnt_q         <= 32'd0;
            cs1           <= 1'b1;
            cs2           <= 1'b1;
            data_received <= rx_q;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // In idle (and during reset) sclk follows the live cpol input
  assign sclk      = (state_q == S_IDLE) ? cpol : sclk_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of transfers plus hand-written
// timing, busy/priority and abort sequences, with an SPI slave model on the bus.
module tb_spi_master;

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, pulse1, pulse2, cpol, cpha, miso;
  logic [31:0] speed;
  logic [7:0]  data2send;
  logic        sclk, cs1, cs2, mosi;
  logic [7:0]  data_received;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // slave / monitor state
  logic       m_cpol, m_cpha;
  int         m_sel;
  logic [7:0] sl_sr, cap;
  int         edges, low_cycles, wrong_cs;
  logic       prev_sclk = 1'b0;
  logic       prev_idle = 1'b1;

  typedef struct {
    logic        pol;
    logic        pha;
    int          sel;
    logic [31:0] spd;
    logic [7:0]  tx;
    logic [7:0]  sl;
    int          cyc;
  } vec_t;
  vec_t vecs[7];

  spi_master #(.CLK_FREQ_HZ(100_000_000)) dut (
    .clk(clk), .reset(reset), .pulse1(pulse1), .pulse2(pulse2), .speed(speed),
    .cpol(cpol), .cpha(cpha), .data2send(data2send), .miso(miso), .sclk(sclk),
    .cs1(cs1), .cs2(cs2), .mosi(mosi), .data_received(data_received),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave model and bus monitor, evaluated away from the active clock edge
  always @(negedge clk) begin
    if (!cs1 || !cs2) begin
      low_cycles++;
      if ((m_sel == 2) ? !cs1 : !cs2) wrong_cs++;
      if (prev_idle && !m_cpha) begin
        miso  = sl_sr[7];
        sl_sr = {sl_sr[6:0], 1'b0};
      end
      if (sclk != prev_sclk) begin
        edges++;
        if ((sclk != m_cpol) != m_cpha) begin
          cap = {cap[6:0], mosi};
        end else begin
          miso  = sl_sr[7];
          sl_sr = {sl_sr[6:0], 1'b0};
        end
      end
    end
    prev_sclk = sclk;
    prev_idle = cs1 && cs2;
  end

  // Returns at the first negedge with chip select asserted
  task automatic start_xfer(input logic pol, input logic pha, input int sel,
                            input logic [31:0] spd, input logic [7:0] tx, input logic [7:0] sl);
    @(negedge clk);
    cpol = pol; cpha = pha; speed = spd; data2send = tx;
    m_cpol = pol; m_cpha = pha; m_sel = (sel == 2) ? 2 : 1;
    sl_sr = LSB ? rev8(sl) : sl;
    cap = 8'd0; edges = 0; low_cycles = 0; wrong_cs = 0;
    @(negedge clk);
    pulse1 = (sel != 2);
    pulse2 = (sel != 1);
    @(negedge clk);
    pulse1 = 1'b0;
    pulse2 = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input logic [7:0] exp_tx,
                             input logic [7:0] exp_rx, input int exp_cyc);
    int n = 0;
    while (!(cs1 && cs2) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(cs1 && cs2), 32'd1);
    check({tag, "_mosi_byte"}, 32'(cap), 32'(LSB ? rev8(exp_tx) : exp_tx));
    check({tag, "_rx_byte"}, 32'(data_received), 32'(exp_rx));
    check({tag, "_sclk_edges"}, 32'(edges), 32'd16);
    check({tag, "_cs_low_cycles"}, 32'(low_cycles), 32'(exp_cyc));
    check({tag, "_wrong_cs"}, 32'(wrong_cs), 32'd0);
    check({tag, "_sclk_idle"}, 32'(sclk), 32'(m_cpol));
  endtask

  initial begin
    vecs[0] = '{pol: 1'b0, pha: 1'b0, sel: 1, spd: 32'd1_000_000,  tx: 8'hA5, sl: 8'h3C, cyc: 850};
    vecs[1] = '{pol: 1'b0, pha: 1'b1, sel: 2, spd: 32'd1_000_000,  tx: 8'hA5, sl: 8'hC3, cyc: 850};
    vecs[2] = '{pol: 1'b1, pha: 1'b0, sel: 1, spd: 32'd5_000_000,  tx: 8'h3C, sl: 8'h81, cyc: 170};
    vecs[3] = '{pol: 1'b1, pha: 1'b1, sel: 2, spd: 32'd10_000_000, tx: 8'h81, sl: 8'h7E, cyc: 85};
    vecs[4] = '{pol: 1'b0, pha: 1'b0, sel: 3, spd: 32'd0,          tx: 8'hFF, sl: 8'h00, cyc: 17};
    vecs[5] = '{pol: 1'b0, pha: 1'b1, sel: 1, spd: 32'd200_000_000, tx: 8'h00, sl: 8'hFF, cyc: 17};
    vecs[6] = '{pol: 1'b0, pha: 1'b0, sel: 2, spd: 32'd3_000_000,  tx: 8'h5A, sl: 8'hA5, cyc: 272};

    reset = 1'b0; pulse1 = 1'b0; pulse2 = 1'b0; cpol = 1'b0; cpha = 1'b0; miso = 1'b0;
    speed = 32'd1_000_000; data2send = 8'h00;
    m_cpol = 1'b0; m_cpha = 1'b0; m_sel = 1; sl_sr = 8'h00; cap = 8'h00;
    edges = 0; low_cycles = 0; wrong_cs = 0;

    // Reset: hold low for 100 ns
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_cs1", 32'(cs1), 32'd1);
    check("rst_cs2", 32'(cs2), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_data_received", 32'(data_received), 32'd0);

    // Mode 0 timing at 1 MHz: half period 50 cycles
    start_xfer(1'b0, 1'b0, 1, 32'd1_000_000, 8'hA5, 8'h3C);
    check("m0_cs1_low", 32'(cs1), 32'd0);
    check("m0_mosi_first", 32'(mosi), 32'd1);
    check("m0_sclk_start", 32'(sclk), 32'd0);
    repeat (75) @(negedge clk);
    check("m0_sclk_0p75us", 32'(sclk), 32'd1);
    finish_xfer("m0", 8'hA5, 8'h3C, 850);

    // Table of transfers
    for (int i = 0; i < 7; i++) begin
      start_xfer(vecs[i].pol, vecs[i].pha, vecs[i].sel, vecs[i].spd, vecs[i].tx, vecs[i].sl);
      finish_xfer($sformatf("v%0d", i), vecs[i].tx, vecs[i].sl, vecs[i].cyc);
    end

    // Busy: extra pulses and input changes mid-transfer are ignored
    start_xfer(1'b0, 1'b0, 1, 32'd1_000_000, 8'hA5, 8'h5A);
    repeat (300) @(negedge clk);
    pulse2 = 1'b1; data2send = 8'h00; cpha = 1'b1; speed = 32'd0;
    @(negedge clk);
    pulse2 = 1'b0; pulse1 = 1'b1;
    @(negedge clk);
    pulse1 = 1'b0;
    repeat (100) @(negedge clk);
    cpha = 1'b0;
    finish_xfer("busy", 8'hA5, 8'h5A, 850);

    // Abort during bit 4, asynchronously
    start_xfer(1'b0, 1'b0, 1, 32'd1_000_000, 8'hA5, 8'h3C);
    repeat (370) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_cs1", 32'(cs1), 32'd1);
    check("abort_cs2", 32'(cs2), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_data_received", 32'(data_received), 32'd0);
    check("abort_state", 32'(state_dbg), 32'd0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    start_xfer(1'b0, 1'b1, 1, 32'd1_000_000, 8'hC3, 8'h96);
    finish_xfer("post_abort", 8'hC3, 8'h96, 850);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI master with two chip selects and runtime-selectable mode (CPOL/CPHA) and SCLK rate.
- A one-cycle start pulse selects the slave (pulse1 → cs1, pulse2 → cs2); the block then shifts 8 bits out on mosi MSB-first and samples 8 bits from miso.
- Sits between a host controller and up to two SPI slaves; the received byte is held on data_received until the next transfer completes.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz; used to derive the SCLK half-period from speed.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- pulse1  input  1  start a transfer to slave 1; one-cycle strobe.
- pulse2  input  1  start a transfer to slave 2; one-cycle strobe.
- speed  input  32  SCLK frequency in Hz.
- cpol  input  1  SCLK idle level.
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge.
- data2send  input  8  byte to transmit.
- miso  input  1  serial data from slave.
- sclk  output  1  SPI clock.
- cs1  output  1  chip select 1, active-low.
- cs2  output  1  chip select 2, active-low.
- mosi  output  1  serial data to slave.
- data_received  output  8  last received byte.

Behaviour:
- Reset (reset=0, async): sclk=cpol, cs1=cs2=1, mosi=0, data_received=0, FSM=IDLE.
- HALF = max(1, CLK_FREQ_HZ/(2*speed)) clk cycles. Use 1 when speed=0.
- States: IDLE → SHIFT → END → IDLE.
- IDLE:
  - sclk tracks cpol.
  - On pulse1 or pulse2, latch data2send, cpol, cpha, HALF and slave select.
  - If pulse1 and pulse2 are asserted together, pulse1 wins.
  - On the next edge, drive the selected cs low and enter SHIFT.
- SHIFT:
  - A half-period counter toggles sclk every HALF cycles; 16 toggles total (8 SCLK periods).
  - cpha=0: mosi=bit7 as cs asserts; sample miso on odd toggles (leading edges); shift the next bit onto mosi on even toggles.
  - cpha=1: shift a bit onto mosi on odd toggles; sample miso on even toggles.
  - Bits are received MSB-first: the first sampled bit becomes data_received[7].
- END:
  - Entered after the 16th toggle; sclk is at cpol.
  - Hold for HALF cycles, then cs1=cs2=1.
  - Load data_received with the 8 sampled bits in the same cycle, then return to IDLE.
- Start pulses arriving outside IDLE are ignored.
- Input changes mid-transfer have no effect (all configuration is latched).
- Reset mid-transfer aborts immediately to reset values. A partial byte is discarded.
- Only one cs is low at any time. cs stays low for the whole byte.
- Timing: at speed=1_000_000 and 100 MHz, one byte takes 8 µs plus one extra half-period, and SCLK toggles every 0.5 µs.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: transmit data2send[0] first and place the first sampled bit in data_received[0] (LSB-first on both directions).
- Undefined: MSB-first as specified above.

Test Plan:
- Reset: hold reset=0 for 100 ns, then release → sclk=0 (cpol=0), cs1=cs2=1, data_received=0x00.
- Mode 0 transfer: cpol=0, cpha=0, speed=1_000_000, data2send=0xA5, one-cycle pulse1.
  - cs1 falls and mosi=1 immediately; sclk=0 just after start and 1 at 0.75 µs.
  - mosi shows 1,0,1,0,0,1,0,1 at 1 µs spacing.
  - After the byte, sclk=0 and cs1=cs2=1.
- Mode 1 on cs2: cpha=1, same data, pulse2 → cs2 low and cs1 high throughout; mosi carries 0xA5 MSB-first, changing on rising edges.
- Receive: slave drives miso with 0x3C MSB-first, aligned to the sampling edges → data_received=0x3C after cs rises.
- Busy and priority:
  - pulse1 and pulse2 in the same cycle → only cs1 asserts.
  - A second pulse mid-transfer is ignored; the byte count stays 8.
- Abort: assert reset during bit 4 → cs1=1, sclk=cpol and data_received=0x00 asynchronously; after release the next pulse1 performs a full clean transfer.
